// File: rtl/cnc_segment_scheduler_if.sv
// Host/interpolator-side signal bundle for cnc_segment_scheduler.
// The master side drives the command inputs; the slave side is the scheduler.
interface cnc_segment_scheduler_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          WR;
    logic [7:0]    Nx;
    logic [7:0]    Ny;
    logic          start;
    logic          LS;
    logic          seg_load;
    logic [7:0]    seg_x;
    logic [7:0]    seg_y;
    logic          seg_valid;
    logic          dda_en;
    logic          busy;
    logic          flag_full;
    logic          flag_empty;
    logic [LW-1:0] level;
    logic          underrun;
    logic          fault;

    modport master (
        output WR, Nx, Ny, start, LS,
        input  seg_load, seg_x, seg_y, seg_valid, dda_en, busy,
               flag_full, flag_empty, level, underrun, fault
    );

    modport slave (
        input  WR, Nx, Ny, start, LS,
        output seg_load, seg_x, seg_y, seg_valid, dda_en, busy,
               flag_full, flag_empty, level, underrun, fault
    );
endinterface

// File: rtl/cnc_segment_scheduler.sv
// Segment FIFO plus period timer feeding the 2-axis DDA interpolators:
// one period-aligned segment load per PERIOD clocks, sub-step strobes, LS abort.
module cnc_segment_scheduler #(
    parameter int DEPTH  = 4,
    parameter int PERIOD = 1000,
    parameter int SUB    = 100
) (
    input logic                     clk,
    input logic                     rst_n,
    cnc_segment_scheduler_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(PERIOD);
    localparam int SW = $clog2(SUB);
    localparam logic [LW-1:0] FULL  = LW'(DEPTH);
    localparam logic [TW-1:0] TLAST = TW'(PERIOD - 1);
    localparam logic [SW-1:0] SLAST = SW'(SUB - 1);
    localparam logic [SW-1:0] SHALF = SW'(SUB / 2);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT} state_t;

    state_t        r_state;
    logic          r_wr_d;
    logic [15:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [TW-1:0] r_timer;
    logic [SW-1:0] r_sub;
    logic          r_seg_load;
    logic [7:0]    r_seg_x;
    logic [7:0]    r_seg_y;
    logic          r_seg_valid;
    logic          r_dda_en;
    logic          r_busy;
    logic          r_flag_full;
    logic          r_flag_empty;
    logic          r_underrun;
    logic          r_fault;

    logic          w_push;
    logic          w_empty;
    logic          w_boundary;
    logic          w_pop;
    logic          w_push_ok;
    logic [LW-1:0] w_level_nxt;
    logic [15:0]   w_head;
    logic [SW-1:0] w_sub_nxt;

    always_comb begin
        w_push      = bus.WR & ~r_wr_d;
        w_empty     = (r_level == '0);
        w_boundary  = (r_state == S_RUN) && (r_timer == TLAST);
        w_pop       = !bus.LS && !w_empty &&
                      (((r_state == S_IDLE) && bus.start) || w_boundary);
        // A full FIFO still accepts a push when the same cycle pops the old head.
        w_push_ok   = w_push && !bus.LS && (r_state != S_FAULT) &&
                      ((r_level != FULL) || w_pop);
        w_level_nxt = bus.LS ? '0 : r_level + LW'(w_push_ok) - LW'(w_pop);
        w_head      = r_mem[r_rptr];
        w_sub_nxt   = (r_sub == SLAST) ? '0 : r_sub + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wptr] <= {bus.Nx, bus.Ny};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wr_d       <= 1'b0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_level      <= '0;
            r_timer      <= '0;
            r_sub        <= '0;
            r_seg_load   <= 1'b0;
            r_seg_x      <= '0;
            r_seg_y      <= '0;
            r_seg_valid  <= 1'b0;
            r_dda_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_flag_full  <= 1'b0;
            r_flag_empty <= 1'b1;
            r_underrun   <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_wr_d       <= bus.WR;
            r_seg_load   <= 1'b0;
            r_dda_en     <= 1'b0;
            r_level      <= w_level_nxt;
            r_flag_full  <= (w_level_nxt == FULL);
            r_flag_empty <= (w_level_nxt == '0);
            if (w_push_ok)
                r_wptr <= r_wptr + PW'(1);
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);

            if (bus.LS) begin
                // Flush and clear the interpolators once on entry only.
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_timer <= '0;
                r_sub   <= '0;
                r_state <= S_FAULT;
                r_busy  <= 1'b0;
                r_fault <= 1'b1;
                if (r_state != S_FAULT) begin
                    r_seg_load  <= 1'b1;
                    r_seg_x     <= '0;
                    r_seg_y     <= '0;
                    r_seg_valid <= 1'b0;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_timer <= '0;
                        r_sub   <= '0;
                        if (!bus.start)
                            r_underrun <= 1'b0;
                        if (w_pop) begin
                            r_seg_load  <= 1'b1;
                            r_seg_x     <= w_head[15:8];
                            r_seg_y     <= w_head[7:0];
                            r_seg_valid <= 1'b1;
                            r_state     <= S_RUN;
                            r_busy      <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (w_boundary) begin
                            r_timer    <= '0;
                            r_sub      <= '0;
                            r_seg_load <= 1'b1;
                            if (!w_empty) begin
                                r_seg_x     <= w_head[15:8];
                                r_seg_y     <= w_head[7:0];
                                r_seg_valid <= 1'b1;
                            end else begin
                                r_seg_x     <= '0;
                                r_seg_y     <= '0;
                                r_seg_valid <= 1'b0;
                                if (bus.start) begin
                                    r_underrun <= 1'b1;
                                end else begin
                                    r_state <= S_IDLE;
                                    r_busy  <= 1'b0;
                                end
                            end
                        end else begin
                            r_timer  <= r_timer + TW'(1);
                            r_sub    <= w_sub_nxt;
                            r_dda_en <= (w_sub_nxt == SHALF);
                        end
                    end
                    S_FAULT: begin
                        r_timer <= '0;
                        r_sub   <= '0;
                        if (!bus.start) begin
                            r_state <= S_IDLE;
                            r_fault <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_fault <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.seg_load   = r_seg_load;
    assign bus.seg_x      = r_seg_x;
    assign bus.seg_y      = r_seg_y;
    assign bus.seg_valid  = r_seg_valid;
    assign bus.dda_en     = r_dda_en;
    assign bus.busy       = r_busy;
    assign bus.flag_full  = r_flag_full;
    assign bus.flag_empty = r_flag_empty;
    assign bus.level      = r_level;
    assign bus.underrun   = r_underrun;
    assign bus.fault      = r_fault;
endmodule

// File: tb/tb_cnc_segment_scheduler.sv
// Directed bench for cnc_segment_scheduler with PERIOD=20, SUB=5, DEPTH=4.
module tb_cnc_segment_scheduler;
    localparam int DEPTH  = 4;
    localparam int PERIOD = 20;
    localparam int SUB    = 5;
    localparam logic [31:0] DDA_MASK = 32'h0002_1084;  // dda_en at k = 2, 7, 12, 17

    typedef struct {
        logic       start_after;
        logic [7:0] x;
        logic [7:0] y;
        logic       valid;
        logic       underrun;
        logic       busy;
        logic [2:0] level;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cnc_segment_scheduler_if #(.DEPTH(DEPTH)) bus ();

    cnc_segment_scheduler #(
        .DEPTH (DEPTH),
        .PERIOD(PERIOD),
        .SUB   (SUB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] x, input logic [7:0] y);
        bus.WR = 1'b1;
        bus.Nx = x;
        bus.Ny = y;
        tick();
        bus.WR = 1'b0;
        tick();
    endtask

    task automatic wait_load(input string name, input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.seg_load && n < max);
        chk(name, 32'(bus.seg_load), 32'd1);
    endtask

    function automatic logic [31:0] outs();
        return {5'd0, bus.seg_load, bus.seg_x, bus.seg_y, bus.seg_valid, bus.dda_en,
                bus.busy, bus.flag_full, bus.flag_empty, bus.level, bus.underrun, bus.fault};
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [5];
        logic [31:0] obs_dda;
        logic [31:0] obs_ld;
        int          n;
        int          cnt;
        logic [15:0] drain [4];

        tbl[0] = '{1'b1, 8'h05, 8'h83, 1'b1, 1'b0, 1'b1, 3'd2};
        tbl[1] = '{1'b1, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b1, 3'd1};
        tbl[2] = '{1'b1, 8'h81, 8'h81, 1'b1, 1'b0, 1'b1, 3'd0};
        tbl[3] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0};
        tbl[4] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0};
        drain[0] = 16'h1323;
        drain[1] = 16'h1424;
        drain[2] = 16'h1626;
        drain[3] = 16'h1727;

        bus.WR = 1'b0; bus.Nx = '0; bus.Ny = '0; bus.start = 1'b0; bus.LS = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 32'h20);
        rst_n = 1'b1;
        tick();

        // Three queued segments, then underrun, then stop.
        push(8'h05, 8'h83);
        push(8'h7F, 8'h00);
        push(8'h81, 8'h81);
        chk("preload_level", 32'(bus.level), 32'd3);
        chk("preload_no_load", 32'(bus.seg_load), 32'd0);
        bus.start = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("vec%0d_load", i), 32'(bus.seg_load), 32'd1);
            chk($sformatf("vec%0d_seg", i), {16'd0, bus.seg_x, bus.seg_y}, {16'd0, tbl[i].x, tbl[i].y});
            chk($sformatf("vec%0d_valid", i), 32'(bus.seg_valid), 32'(tbl[i].valid));
            chk($sformatf("vec%0d_underrun", i), 32'(bus.underrun), 32'(tbl[i].underrun));
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d_level", i), 32'(bus.level), 32'(tbl[i].level));
            bus.start = tbl[i].start_after;
            obs_dda = '0;
            obs_ld  = '0;
            for (int k = 1; k < PERIOD; k++) begin
                tick();
                obs_dda[k] = bus.dda_en;
                obs_ld[k]  = bus.seg_load;
            end
            chk($sformatf("vec%0d_dda_pattern", i), obs_dda, tbl[i].busy ? DDA_MASK : 32'd0);
            chk($sformatf("vec%0d_no_midperiod_load", i), obs_ld, 32'd0);
            tick();
        end
        chk("idle_no_load", 32'(bus.seg_load), 32'd0);
        chk("idle_underrun_cleared", 32'(bus.underrun), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Full FIFO: drop on overflow, accept a push on a boundary pop.
        push(8'h11, 8'h21);
        push(8'h12, 8'h22);
        push(8'h13, 8'h23);
        push(8'h14, 8'h24);
        chk("full_level", 32'(bus.level), 32'd4);
        chk("full_flag", 32'(bus.flag_full), 32'd1);
        push(8'h15, 8'h25);
        chk("overflow_dropped_level", 32'(bus.level), 32'd4);
        bus.start = 1'b1;
        tick();
        chk("full_first_load", {16'd0, bus.seg_x, bus.seg_y}, 32'h1121);
        chk("full_after_pop_level", 32'(bus.level), 32'd3);
        push(8'h16, 8'h26);
        chk("refill_level", 32'(bus.level), 32'd4);
        repeat (PERIOD - 3) tick();
        bus.WR = 1'b1; bus.Nx = 8'h17; bus.Ny = 8'h27;
        tick();
        chk("boundary_push_load", 32'(bus.seg_load), 32'd1);
        chk("boundary_push_seg", {16'd0, bus.seg_x, bus.seg_y}, 32'h1222);
        chk("boundary_push_level", 32'(bus.level), 32'd4);
        chk("boundary_push_full", 32'(bus.flag_full), 32'd1);
        bus.WR = 1'b0;
        bus.start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            wait_load($sformatf("drain%0d_timeout", j), PERIOD + 5, n);
            chk($sformatf("drain%0d_interval", j), 32'(n), 32'(PERIOD));
            chk($sformatf("drain%0d_seg", j), {16'd0, bus.seg_x, bus.seg_y}, {16'd0, drain[j]});
        end
        wait_load("stop_timeout", PERIOD + 5, n);
        chk("stop_seg", {16'd0, bus.seg_x, bus.seg_y, 7'd0, bus.seg_valid}, 32'd0);
        chk("stop_busy", 32'(bus.busy), 32'd0);

        // Limit switch abort mid-period.
        push(8'h31, 8'h41);
        push(8'h32, 8'h42);
        push(8'h33, 8'h43);
        bus.start = 1'b1;
        tick();
        chk("ls_pre_level", 32'(bus.level), 32'd2);
        repeat (5) tick();
        bus.LS = 1'b1;
        tick();
        chk("ls_abort_outputs", outs(), 32'h0400_0021);
        tick();
        chk("ls_single_pulse", 32'(bus.seg_load), 32'd0);
        push(8'h34, 8'h44);
        chk("ls_push_ignored", 32'(bus.level), 32'd0);
        bus.LS = 1'b0;
        push(8'h35, 8'h45);
        repeat (5) tick();
        chk("fault_hold_with_start", {30'd0, bus.fault, bus.dda_en}, 32'h2);
        chk("fault_push_ignored", 32'(bus.level), 32'd0);
        bus.start = 1'b0;
        tick();
        chk("fault_exit", {30'd0, bus.fault, bus.busy}, 32'd0);

        // Pushes without start never load; start then loads next cycle.
        push(8'h51, 8'h61);
        push(8'h52, 8'h62);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.seg_load) cnt++;
        end
        chk("nostart_no_load", 32'(cnt), 32'd0);
        chk("nostart_level", 32'(bus.level), 32'd2);
        bus.start = 1'b1;
        tick();
        chk("start_first_load", {15'd0, bus.seg_load, bus.seg_x, bus.seg_y}, 32'h0001_5161);
        repeat (7) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 32'h20);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.seg_load) cnt++;
        end
        chk("post_reset_no_load", 32'(cnt), 32'd0);
        chk("post_reset_outputs", outs(), 32'h20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cnc_segment_scheduler.md
Name: cnc_segment_scheduler

Overview:
- Controller ahead of the 2-axis DDA step interpolators.
- Accepts X/Y segment bytes from the host through a WR-strobed FIFO and releases exactly one segment per fixed interpolation period.
- Generates the DDA sub-step enable strobe.
- Handles start/stop, underrun and limit-switch abort, so the interpolators only see clean, period-aligned loads.

Parameters:
- DEPTH, 4: segment FIFO entries (power of two, at least 2).
- PERIOD, 1000: clk cycles per interpolation period.
- SUB, 100: clk cycles per DDA sub-step. PERIOD is a multiple of SUB; SUB is at least 2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- WR  in  1  write strobe, synchronous to clk; a 0->1 transition between consecutive samples is one write
- Nx  in  8  X segment byte: bit7 = direction, bits6:0 = step count per period
- Ny  in  8  Y segment byte, same format as Nx
- start  in  1  level; 1 = run enabled
- LS  in  1  limit switch, active high
- seg_load  out  1  1-cycle pulse; seg_x, seg_y and seg_valid change in the same cycle
- seg_x  out  8  current X segment, held between loads
- seg_y  out  8  current Y segment, held between loads
- seg_valid  out  1  1 = current segment came from the FIFO; 0 = zero filler
- dda_en  out  1  1-cycle DDA sub-step enable
- busy  out  1  state == RUN
- flag_full  out  1  level == DEPTH
- flag_empty  out  1  level == 0
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- underrun  out  1  sticky; FIFO was empty at a period boundary while start was high
- fault  out  1  1 while state == FAULT

Behaviour:
- Reset: all outputs 0 except flag_empty = 1. FIFO empty, timer = 0, WR edge register = 0, state IDLE.
- All outputs are registered.

Write path:
- A WR rising edge pushes {Nx, Ny}.
- The push is accepted if level < DEPTH, or if a pop occurs in the same cycle.
- Otherwise the push is dropped silently; FIFO contents are unchanged.
- In FAULT, pushes are ignored.
- Push and pop in the same cycle leave level unchanged; the popped entry is the old head.

FSM states: IDLE, RUN, FAULT.

IDLE:
- timer held at 0, dda_en = 0.
- If start = 1, flag_empty = 0 and LS = 0: pop the head and, in the next cycle, assert seg_load with seg_valid = 1; state becomes RUN and timer = 0.

RUN:
- timer increments each cycle; the cycle carrying seg_load is timer = 0.
- At timer == PERIOD-1 the next cycle is a boundary, so loads occur exactly every PERIOD cycles. At the boundary seg_load = 1 and timer wraps to 0.
- Boundary, FIFO non-empty: pop, seg_valid = 1. This happens regardless of start, so a falling start drains the queue.
- Boundary, FIFO empty, start = 1: seg_x = seg_y = 0, seg_valid = 0, underrun set; stay in RUN.
- Boundary, FIFO empty, start = 0: load zeros, seg_valid = 0; state becomes IDLE.
- dda_en = 1 when (timer mod SUB) == SUB/2, giving PERIOD/SUB pulses per period. It never coincides with seg_load.

Any state, LS = 1:
- Next cycle: state FAULT, FIFO flushed (level = 0), seg_x = seg_y = 0, seg_valid = 0, and one seg_load pulse so the interpolators clear.
- dda_en = 0 and timer = 0 while in FAULT.
- FAULT is left for IDLE only when LS = 0 and start = 0 in the same cycle.
- LS takes priority over a boundary or a write in the same cycle.

underrun:
- Cleared when start = 0 in IDLE.
- Never cleared by a boundary.

Mid-operation reset (rst_n low):
- Immediate return to the reset values, including a FIFO flush.
- No seg_load pulse is generated.

Test Plan:
- PERIOD = 20, SUB = 5. Push 3 segments (0x05/0x83, 0x7F/0x00, 0x81/0x81), start = 1 -> seg_load at t0, t0+20, t0+40 with those values in order. seg_valid = 1. dda_en at timer 2, 7, 12, 17 of each period.
- Keep start = 1 after the queue empties -> at t0+60 seg_load with seg_x = seg_y = 0, seg_valid = 0, underrun = 1, busy stays 1. Drop start -> IDLE at the next boundary; underrun clears in IDLE.
- Fill 4 entries: level = 4, flag_full = 1; a 5th push is dropped. Push exactly on a boundary pop while full -> accepted, level stays 4, FIFO order preserved.
- Raise LS mid-period with 2 entries queued -> next cycle fault = 1, level = 0, one seg_load with zeros. WR edges are ignored. LS = 0 with start = 1 stays in FAULT; start = 0 then returns to IDLE.
- Two pushes without start -> no seg_load. Raise start -> first seg_load one cycle later.
- Assert rst_n = 0 mid-RUN -> all outputs return to their reset values asynchronously, with no extra seg_load after release.
